// File: rtl/diff_demo_pkg.sv
// Shared configuration and types for the diff core unload path.
package diff_demo_pkg;

  localparam int unsigned CONF_PE_COL       = 4;
  localparam int unsigned CONF_FM_BUF_DEPTH = 1024;
  localparam int unsigned FM_WORD_BYTES     = 9;
  localparam int unsigned FM_WORD_W         = FM_WORD_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM,
    DONE
  } fm_stream_state_e;

  // One fm buffer word viewed as bytes; index 0 is the LSB byte.
  typedef logic [FM_WORD_BYTES-1:0][7:0] fm_word_t;

endpackage

// File: rtl/fm_word_serializer.sv
// Holds the word being unloaded and walks its bytes LSB first onto an
// 8-bit AXI-Stream. A new word can be loaded on the final byte handshake
// so consecutive words leave without a bubble.
module fm_word_serializer
  import diff_demo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  fm_word_t   word_i,
  input  logic       last_i,
  input  logic       tready_i,
  output logic       tvalid_o,
  output logic [7:0] tdata_o,
  output logic       tkeep_o,
  output logic       tlast_o,
  output logic       word_done_c_o,
  output logic       last_hs_c_o
);

  localparam int unsigned IDX_W = $clog2(FM_WORD_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FM_WORD_BYTES - 1);

  fm_word_t         word_q, word_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_word_q, last_word_d;
  logic             tvalid_q, tvalid_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tlast_q, tlast_d;
  logic             hs_c;

  assign hs_c          = tvalid_q && tready_i;
  assign word_done_c_o = hs_c && (idx_q == LAST_IDX);
  assign last_hs_c_o   = hs_c && tlast_q;

  // Byte walk: load restarts at byte 0, each handshake advances one byte
  always_comb begin
    word_d      = word_q;
    idx_d       = idx_q;
    last_word_d = last_word_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    if (load_i) begin
      word_d      = word_i;
      idx_d       = '0;
      last_word_d = last_i;
      tvalid_d    = 1'b1;
      tdata_d     = word_i[0];
      tlast_d     = 1'b0;
    end else if (hs_c) begin
      if (idx_q == LAST_IDX) begin
        tvalid_d = 1'b0;
        tdata_d  = '0;
        tlast_d  = 1'b0;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        tdata_d = word_q[idx_d];
        tlast_d = last_word_q && (idx_d == LAST_IDX);
      end
    end
  end

  // Serializer state and registered stream outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q      <= '0;
      idx_q       <= '0;
      last_word_q <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
    end else begin
      word_q      <= word_d;
      idx_q       <= idx_d;
      last_word_q <= last_word_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
    end
  end

  assign tvalid_o = tvalid_q;
  assign tdata_o  = tdata_q;
  assign tkeep_o  = tvalid_q;
  assign tlast_o  = tlast_q;

endmodule

// File: rtl/fm_save_streamer.sv
// Unloads the per-column fm buffers through the save port and streams them
// as bytes to the s2mm datamover: column 0 words 0..word_cnt-1, then the
// next column, each word LSB byte first. One word is prefetched ahead so the
// stream runs at one byte per cycle without gaps.
// Optional build macro FM_STREAM_STALL_CNT_EN adds the stall_cnt output.
module fm_save_streamer
  import diff_demo_pkg::*;
#(
  parameter int unsigned PE_COL    = CONF_PE_COL,
  parameter int unsigned FM_ADDR_W = $clog2(CONF_FM_BUF_DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [FM_ADDR_W:0]                  word_cnt,
  output logic                                busy,
  output logic                                done,
  output logic [PE_COL-1:0][FM_ADDR_W-1:0]    save_fm_rd_addr,
  input  logic [PE_COL-1:0][FM_WORD_W-1:0]    save_fm_dout,
  output logic                                m_axis_s2mm_tvalid,
  input  logic                                m_axis_s2mm_tready,
  output logic [7:0]                          m_axis_s2mm_tdata,
  output logic                                m_axis_s2mm_tkeep,
  output logic                                m_axis_s2mm_tlast
`ifdef FM_STREAM_STALL_CNT_EN
  ,
  output logic [31:0]                         stall_cnt
`endif
);

  localparam int unsigned COL_W = (PE_COL > 1) ? $clog2(PE_COL) : 1;
  localparam int unsigned CNT_W = FM_ADDR_W + 1;

  fm_stream_state_e state_q, state_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Read issue position: last address handed to the buffers
  logic [COL_W-1:0] iss_col_q;
  logic [CNT_W-1:0] iss_word_q;
  logic             iss_final_q;
  logic [COL_W-1:0] adv_col_c;
  logic [CNT_W-1:0] adv_word_c;

  logic             issue_c;
  logic [COL_W-1:0] issue_col_c;
  logic [CNT_W-1:0] issue_word_c;
  logic             issue_final_c;

  // Read pipeline: stage 1 address on the port, stage 2 data on dout
  logic             rd_s1_q, rd_s2_q;
  logic [COL_W-1:0] rd_col_s1_q, rd_col_s2_q;
  logic             rd_last_s1_q, rd_last_s2_q;
  fm_word_t         rd_data_c;

  fm_word_t         nxt_word_q;
  logic             nxt_last_q;
  logic [PE_COL-1:0][FM_ADDR_W-1:0] rd_addr_q;

  logic             load_c;
  fm_word_t         load_word_c;
  logic             load_last_c;
  logic             word_done_c;
  logic             last_hs_c;

  assign rd_data_c = fm_word_t'(save_fm_dout[rd_col_s2_q]);

  // Position following the last issued read (next word or next column)
  always_comb begin
    if ((iss_word_q + CNT_W'(1)) < words_q) begin
      adv_col_c  = iss_col_q;
      adv_word_c = iss_word_q + CNT_W'(1);
    end else begin
      adv_col_c  = iss_col_q + COL_W'(1);
      adv_word_c = '0;
    end
  end

  // Next-state, read issue and serializer load control
  always_comb begin
    state_d      = state_q;
    words_d      = words_q;
    done_d       = 1'b0;
    issue_c      = 1'b0;
    issue_col_c  = adv_col_c;
    issue_word_c = adv_word_c;
    load_c       = 1'b0;
    load_word_c  = nxt_word_q;
    load_last_c  = nxt_last_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (word_cnt != '0) begin
            state_d      = FETCH;
            words_d      = word_cnt;
            issue_c      = 1'b1;
            issue_col_c  = '0;
            issue_word_c = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (rd_s2_q) begin
          load_c      = 1'b1;
          load_word_c = rd_data_c;
          load_last_c = rd_last_s2_q;
          issue_c     = !iss_final_q;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (last_hs_c) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (word_done_c) begin
          load_c  = 1'b1;
          issue_c = !iss_final_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == FETCH) || (state_d == STREAM);
  end

  assign issue_final_c = (issue_col_c == COL_W'(PE_COL - 1)) &&
                         ((issue_word_c + CNT_W'(1)) == words_d);

  // FSM, address counters, read pipeline and prefetch buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      words_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      iss_col_q    <= '0;
      iss_word_q   <= '0;
      iss_final_q  <= 1'b0;
      rd_s1_q      <= 1'b0;
      rd_s2_q      <= 1'b0;
      rd_col_s1_q  <= '0;
      rd_col_s2_q  <= '0;
      rd_last_s1_q <= 1'b0;
      rd_last_s2_q <= 1'b0;
      nxt_word_q   <= '0;
      nxt_last_q   <= 1'b0;
      rd_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      words_q      <= words_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_s1_q      <= issue_c;
      rd_col_s1_q  <= issue_col_c;
      rd_last_s1_q <= issue_final_c;
      rd_s2_q      <= rd_s1_q;
      rd_col_s2_q  <= rd_col_s1_q;
      rd_last_s2_q <= rd_last_s1_q;
      if (issue_c) begin
        iss_col_q              <= issue_col_c;
        iss_word_q             <= issue_word_c;
        iss_final_q            <= issue_final_c;
        rd_addr_q[issue_col_c] <= FM_ADDR_W'(issue_word_c);
      end
      if (rd_s2_q && (state_q == STREAM)) begin
        nxt_word_q <= rd_data_c;
        nxt_last_q <= rd_last_s2_q;
      end
    end
  end

  fm_word_serializer u_ser (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (load_c),
    .word_i        (load_word_c),
    .last_i        (load_last_c),
    .tready_i      (m_axis_s2mm_tready),
    .tvalid_o      (m_axis_s2mm_tvalid),
    .tdata_o       (m_axis_s2mm_tdata),
    .tkeep_o       (m_axis_s2mm_tkeep),
    .tlast_o       (m_axis_s2mm_tlast),
    .word_done_c_o (word_done_c),
    .last_hs_c_o   (last_hs_c)
  );

  assign busy            = busy_q;
  assign done            = done_q;
  assign save_fm_rd_addr = rd_addr_q;

`ifdef FM_STREAM_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Stalled beats of the current transfer, saturating, held after done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      stall_cnt_q <= '0;
    end else if (m_axis_s2mm_tvalid && !m_axis_s2mm_tready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fm_save_streamer.sv
// Scoreboard bench for fm_save_streamer: expected bytes are queued when a
// transfer is started, a monitor pops and compares on every handshake.
module tb_fm_save_streamer;

  localparam int unsigned PE_COL    = 4;
  localparam int unsigned FM_ADDR_W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [FM_ADDR_W:0] word_cnt = '0;
  logic busy, done;
  logic [PE_COL-1:0][FM_ADDR_W-1:0] rd_addr;
  logic [PE_COL-1:0][71:0] dout;
  logic tvalid, tready, tkeep, tlast;
  logic [7:0] tdata;
`ifdef FM_STREAM_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int hs_seen = 0;
  int done_seen = 0;
  int stall_seen = 0;
  bit tready_toggle = 1'b0;
  logic [8:0] exp_q[$];

  fm_save_streamer #(.PE_COL(PE_COL), .FM_ADDR_W(FM_ADDR_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .word_cnt           (word_cnt),
    .busy               (busy),
    .done               (done),
    .save_fm_rd_addr    (rd_addr),
    .save_fm_dout       (dout),
    .m_axis_s2mm_tvalid (tvalid),
    .m_axis_s2mm_tready (tready),
    .m_axis_s2mm_tdata  (tdata),
    .m_axis_s2mm_tkeep  (tkeep),
    .m_axis_s2mm_tlast  (tlast)
`ifdef FM_STREAM_STALL_CNT_EN
    ,
    .stall_cnt          (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Buffer contents: 7 incrementing bytes, then addr low byte, then col/addr high
  function automatic logic [71:0] mem_word(input int c, input int a);
    logic [71:0] w;
    for (int k = 0; k < 7; k++) w[8*k +: 8] = 8'(c * 37 + a * 3 + k);
    w[63:56] = 8'(a);
    w[71:64] = 8'((c << 4) | (a >> 8));
    return w;
  endfunction

  // Fm buffers: registered read, data one cycle after the address
  always @(posedge clk) begin
    for (int c = 0; c < PE_COL; c++) dout[c] <= mem_word(c, int'(rd_addr[c]));
  end

  // tready driver: held high, or toggling every cycle
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tready_toggle) tready = ~tready;
      else tready = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_expected(input int words);
    logic [71:0] w;
    for (int c = 0; c < PE_COL; c++)
      for (int a = 0; a < words; a++) begin
        w = mem_word(c, a);
        for (int k = 0; k < 9; k++)
          exp_q.push_back({(c == PE_COL - 1) && (a == words - 1) && (k == 8), w[8*k +: 8]});
      end
  endtask

  task automatic start_pulse(input int words);
    word_cnt = (FM_ADDR_W + 1)'(words);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: scoreboard pops on handshakes, stall stability, done counting
  initial begin
    logic [8:0] e;
    logic pstall;
    logic [7:0] pdata;
    logic plast;
    pstall = 1'b0;
    pdata = '0;
    plast = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pstall = 1'b0;
      end else begin
        if (pstall) chk("stall hold {tvalid,tlast,tdata}", {55'd0, tvalid, tlast, tdata}, {55'd0, 1'b1, plast, pdata});
        if (tvalid && !tready) stall_seen++;
        if (done) done_seen++;
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected byte: got 0x%0h with nothing queued at %0t", tdata, $time);
          end else begin
            e = exp_q.pop_front();
            chk("stream {tkeep,tlast,tdata}", {54'd0, tkeep, tlast, tdata}, {54'd0, 1'b1, e});
          end
          hs_seen++;
        end
        pstall = tvalid && !tready;
        pdata = tdata;
        plast = tlast;
      end
    end
  end

  // mode 0: tready high; 1: tready toggling; 2: extra starts mid-transfer and in DONE
  task automatic run_xfer(input int words, input int mode);
    int h0, d0, s0, hs, vcyc, gaps, budget;
    bit seen, got_last;
    tready_toggle = (mode == 1);
    d0 = done_seen;
    s0 = stall_seen;
    push_expected(words);
    start_pulse(words);
    h0 = hs_seen;
    hs = 0; vcyc = 0; gaps = 0; seen = 1'b0; got_last = 1'b0;
    budget = words * PE_COL * 9 * 3 + 50;
    for (int n = 0; n < budget && !got_last; n++) begin
      if (tvalid) begin
        seen = 1'b1;
        vcyc++;
      end else if (seen) begin
        gaps++;
      end
      if (tvalid && tready) begin
        hs++;
        if (tlast) got_last = 1'b1;
      end
      start = (mode == 2) && (hs == 20) && !got_last;
      if (!got_last) @(negedge clk);
    end
    start = 1'b0;
    chk("tlast reached within budget", 64'(got_last), 64'd1);
    @(posedge clk);
    #1;
    if (mode == 2) begin
      word_cnt = (FM_ADDR_W + 1)'(1);
      start = 1'b1;
    end
    @(negedge clk);
    chk("done in cycle after tlast", 64'(done), 64'd1);
    chk("busy low in done cycle", 64'(busy), 64'd0);
    chk("tvalid low after tlast", 64'(tvalid), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("done is one cycle", 64'(done), 64'd0);
    chk("idle after done (start in done ignored)", {62'd0, busy, tvalid}, 64'd0);
    chk("done pulse count", 64'(done_seen - d0), 64'd1);
    chk("handshake count", 64'(hs_seen - h0), 64'(words * PE_COL * 9));
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    if (mode != 1) begin
      chk("tvalid cycles", 64'(vcyc), 64'(words * PE_COL * 9));
      chk("tvalid gaps", 64'(gaps), 64'd0);
    end
    for (int c = 0; c < PE_COL; c++)
      chk($sformatf("rd_addr col%0d holds last word", c), 64'(rd_addr[c]), 64'(words - 1));
`ifdef FM_STREAM_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(stall_seen - s0));
`endif
    tready_toggle = 1'b0;
  endtask

  initial begin
    int d0, h0;
    bit hit;
    logic bad;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy/done", {62'd0, busy, done}, 64'd0);
    chk("reset tvalid/tlast/tkeep", {61'd0, tvalid, tlast, tkeep}, 64'd0);
    chk("reset tdata", 64'(tdata), 64'd0);
    chk("reset rd_addr", 64'(rd_addr), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer(2, 0);
    run_xfer(2, 1);

    // Empty transfer: done next cycle, no stream activity
    d0 = done_seen;
    start_pulse(0);
    chk("zero-length done next cycle", 64'(done), 64'd1);
    bad = 1'b0;
    for (int n = 0; n < 6; n++) begin
      bad = bad | tvalid | busy;
      @(negedge clk);
    end
    chk("zero-length no tvalid/busy", 64'(bad), 64'd0);
    chk("zero-length done count", 64'(done_seen - d0), 64'd1);

    run_xfer(2, 2);

    // Reset in the middle of a transfer, then a fresh single-word transfer
    push_expected(2);
    start_pulse(2);
    h0 = hs_seen;
    hit = 1'b0;
    for (int n = 0; n < 500 && !hit; n++) begin
      if (hs_seen - h0 >= 30) hit = 1'b1;
      else @(negedge clk);
    end
    chk("reached byte 30", 64'(hit), 64'd1);
    rst_n = 1'b0;
    d0 = done_seen;
    @(negedge clk);
    chk("tvalid low after reset", 64'(tvalid), 64'd0);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("no done after abort", 64'(done_seen - d0), 64'd0);
    chk("idle after abort", {62'd0, busy, tvalid}, 64'd0);
    run_xfer(1, 0);

    // Full buffer depth: addresses 0..1023 per column, no wrap
    run_xfer(1 << FM_ADDR_W, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
